idct_coef_loader: RTL and testbench

//  Input-side companion of the fully pipelined 64-point IDCT core (x0..x63 in, out0..out63 out).

---
 rtl/idct_coef_loader_if.sv | 29 ++
 rtl/idct_coef_loader.sv | 127 ++++++++++++
 tb/tb_idct_coef_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_coef_loader_if.sv
// idct_coef_loader_if
//   Serial coefficient stream feeding the IDCT input loader.
//   s_valid  source -> loader  beat valid
//   s_ready  loader -> source  loader can take a beat
//   s_data   source -> loader  signed coefficient, DATA_W bits
//   s_last   source -> loader  last beat of the block (EOB when early)
//   master: coefficient source, slave: idct_coef_loader.
interface idct_coef_loader_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/idct_coef_loader.sv
// idct_coef_loader
//   Collects a serial stream of signed coefficients (zig-zag or raster
//   order) into a 64-word block and hands it to a fully pipelined 64-point
//   IDCT as one flat parallel bus. Positions not written before the block
//   closes (EOB) are presented as zero.
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   s            coefficient stream (slave side of idct_coef_loader_if)
//   blk_x        assembled block, x[p] = blk_x[p*DATA_W +: DATA_W]
//   blk_launch   1-cycle pulse, the IDCT samples blk_x in this cycle
//   out_valid    1-cycle pulse LATENCY cycles after each blk_launch
//   blk_cnt      number of launched blocks, wraps at 256
//   err_len      1-cycle pulse with the launch of a block whose 64th beat
//                arrived without s_last
module idct_coef_loader #(
  parameter int DATA_W  = 16,
  parameter int LATENCY = 29,
  parameter bit ZIGZAG  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  idct_coef_loader_if.slave     s,
  output logic [64*DATA_W-1:0]  blk_x,
  output logic                  blk_launch,
  output logic                  out_valid,
  output logic [7:0]            blk_cnt,
  output logic                  err_len
);

  // JPEG zig-zag scan: beat index -> raster position in the 8x8 block.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic              ready_q;
  logic [5:0]        idx;
  logic [63:0]       mask;
  logic [DATA_W-1:0] fill [64];
  logic [LATENCY-1:0] lat_sr;

  logic              accept;
  logic              close_blk;
  logic [5:0]        pos;

  assign s.s_ready = ready_q;
  assign out_valid = lat_sr[LATENCY-1];

  always_comb begin
    accept    = s.s_valid & ready_q;
    close_blk = accept & (s.s_last | (idx == 6'd63));
    pos       = ZIGZAG ? ZZ[idx] : idx;
  end

  // The closing beat bypasses the fill buffer straight into blk_x, so the
  // launch happens the cycle after the last beat. The mask (not the fill
  // buffer contents) decides which words are live, which is what zeroes
  // stale data from a previous block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      idx        <= '0;
      mask       <= '0;
      blk_x      <= '0;
      blk_launch <= 1'b0;
      err_len    <= 1'b0;
      blk_cnt    <= '0;
      for (int q = 0; q < 64; q++) begin
        fill[q] <= '0;
      end
    end else begin
      ready_q    <= 1'b1;
      blk_launch <= close_blk;
      // A close without s_last can only come from the 64th beat.
      err_len    <= close_blk & ~s.s_last;
      if (accept) begin
        fill[pos] <= s.s_data;
        if (close_blk) begin
          idx     <= '0;
          mask    <= '0;
          blk_cnt <= blk_cnt + 8'd1;
          for (int q = 0; q < 64; q++) begin
            if (6'(q) == pos) begin
              blk_x[q*DATA_W +: DATA_W] <= s.s_data;
            end else if (mask[q]) begin
              blk_x[q*DATA_W +: DATA_W] <= fill[q];
            end else begin
              blk_x[q*DATA_W +: DATA_W] <= '0;
            end
          end
        end else begin
          idx       <= idx + 6'd1;
          mask[pos] <= 1'b1;
        end
      end
    end
  end

  // One bit per in-flight launch, so launches on consecutive cycles each
  // get their own out_valid pulse; reset drops everything in flight.
  generate
    if (LATENCY > 1) begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lat_sr <= '0;
        end else begin
          lat_sr <= {lat_sr[LATENCY-2:0], blk_launch};
        end
      end
    end else begin : g_lat_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lat_sr <= '0;
        end else begin
          lat_sr <= blk_launch;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_idct_coef_loader.sv
// tb_idct_coef_loader
//   Drives the same coefficient stream into a zig-zag loader and a raster
//   loader and compares both against a block-level reference model.
//   The model keeps the beats of the open block in a queue and, when the
//   block closes, scatters them into a fresh zeroed 8x8 block. The zig-zag
//   order is generated by walking the anti-diagonals of the 8x8 grid.
module tb_idct_coef_loader;

  localparam int DW  = 16;
  localparam int LAT = 29;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic last;
  logic [DW-1:0] data;

  logic [64*DW-1:0] blk_x_zz, blk_x_rs;
  logic launch_zz, launch_rs;
  logic outv_zz, outv_rs;
  logic [7:0] cnt_zz, cnt_rs;
  logic err_zz, err_rs;

  idct_coef_loader_if #(.DATA_W(DW)) bus_zz ();
  idct_coef_loader_if #(.DATA_W(DW)) bus_rs ();

  assign bus_zz.s_valid = valid;
  assign bus_zz.s_data  = data;
  assign bus_zz.s_last  = last;
  assign bus_rs.s_valid = valid;
  assign bus_rs.s_data  = data;
  assign bus_rs.s_last  = last;

  idct_coef_loader #(.DATA_W(DW), .LATENCY(LAT), .ZIGZAG(1'b1)) dut_zz (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus_zz),
    .blk_x      (blk_x_zz),
    .blk_launch (launch_zz),
    .out_valid  (outv_zz),
    .blk_cnt    (cnt_zz),
    .err_len    (err_zz)
  );

  idct_coef_loader #(.DATA_W(DW), .LATENCY(LAT), .ZIGZAG(1'b0)) dut_rs (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus_rs),
    .blk_x      (blk_x_rs),
    .blk_launch (launch_rs),
    .out_valid  (outv_rs),
    .blk_cnt    (cnt_rs),
    .err_len    (err_rs)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            zz_map [64];
  logic [DW-1:0] exp_zz [64];
  logic [DW-1:0] exp_rs [64];
  logic [DW-1:0] cur [$];
  int            exp_cnt;
  int            err_cyc;
  bit            launch_cyc [int];
  bit            model_ready;
  int            cyc;

  int checks;
  int failures;

  task automatic compare(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1023:0] flatten(input logic [DW-1:0] a [64]);
    logic [1023:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  function automatic void buildZigzag();
    int n;
    n = 0;
    for (int d = 0; d < 15; d++) begin
      int lo, hi;
      lo = (d > 7) ? d - 7 : 0;
      hi = (d < 7) ? d : 7;
      if (d % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_map[n] = r * 8 + (d - r); n++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_map[n] = r * 8 + (d - r); n++; end
      end
    end
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 64; k++) begin exp_zz[k] = '0; exp_rs[k] = '0; end
    cur.delete();
    launch_cyc.delete();
    exp_cnt     = 0;
    err_cyc     = -1;
    model_ready = 1'b0;
  endfunction

  function automatic void modelBeat(input logic [DW-1:0] v, input logic l);
    cur.push_back(v);
    if (l || cur.size() == 64) begin
      for (int k = 0; k < 64; k++) begin exp_zz[k] = '0; exp_rs[k] = '0; end
      for (int k = 0; k < cur.size(); k++) begin
        exp_zz[zz_map[k]] = cur[k];
        exp_rs[k]         = cur[k];
      end
      exp_cnt = (exp_cnt + 1) % 256;
      if (!l) err_cyc = cyc;
      launch_cyc[cyc] = 1'b1;
      cur.delete();
    end
  endfunction

  task automatic checkOutput();
    compare("s_ready_zz", bus_zz.s_ready, model_ready);
    compare("s_ready_rs", bus_rs.s_ready, model_ready);
    compare("launch_zz", launch_zz, launch_cyc.exists(cyc));
    compare("launch_rs", launch_rs, launch_cyc.exists(cyc));
    compare("out_valid_zz", outv_zz, launch_cyc.exists(cyc - LAT));
    compare("out_valid_rs", outv_rs, launch_cyc.exists(cyc - LAT));
    compare("blk_cnt_zz", cnt_zz, exp_cnt[7:0]);
    compare("blk_cnt_rs", cnt_rs, exp_cnt[7:0]);
    compare("err_len_zz", err_zz, cyc == err_cyc);
    compare("err_len_rs", err_rs, cyc == err_cyc);
    compare("blk_x_zz", blk_x_zz, flatten(exp_zz));
    compare("blk_x_rs", blk_x_rs, flatten(exp_rs));
  endtask

  task automatic tick();
    bit acc;
    acc = (valid === 1'b1) && model_ready && (rst_n === 1'b1);
    @(posedge clk);
    cyc++;
    if (acc) modelBeat(data, last);
    model_ready = (rst_n === 1'b1);
    #2;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [DW-1:0] v, input logic l);
    valid = 1'b1;
    data  = v;
    last  = l;
    tick();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    last  = 1'b0;
    data  = $urandom();
    repeat (n) tick();
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    repeat (n) tick();
    rst_n = 1'b1;
    #1;
    compare("s_ready_after_release", bus_zz.s_ready, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    valid    = 1'b0;
    last     = 1'b0;
    data     = '0;
    rst_n    = 1'b1;
    buildZigzag();
    modelReset();
    #1;

    // Reset held for three cycles, then s_ready rises one edge later
    doReset(3);
    idle(1);
    compare("s_ready_up", bus_zz.s_ready, 1'b1);
    idle(2);

    // Full 64-beat block 0,-1,...,-63
    for (int k = 0; k < 64; k++) applyStimulus(DW'(-k), k == 63);
    compare("t2_launch", launch_rs, 1'b1);
    compare("t2_x5_raster", blk_x_rs[5*DW +: DW], 16'hFFFB);
    compare("t2_x63_raster", blk_x_rs[63*DW +: DW], 16'hFFC1);
    compare("t2_cnt", cnt_rs, 8'd1);
    idle(LAT + 1);

    // Zig-zag placement of beats 1..64
    for (int k = 0; k < 64; k++) applyStimulus(DW'(k + 1), k == 63);
    compare("t3_x0", blk_x_zz[0*DW +: DW], 16'd1);
    compare("t3_x1", blk_x_zz[1*DW +: DW], 16'd2);
    compare("t3_x8", blk_x_zz[8*DW +: DW], 16'd3);
    compare("t3_x16", blk_x_zz[16*DW +: DW], 16'd4);
    compare("t3_x9", blk_x_zz[9*DW +: DW], 16'd5);
    compare("t3_x2", blk_x_zz[2*DW +: DW], 16'd6);
    compare("t3_x63", blk_x_zz[63*DW +: DW], 16'd64);
    idle(3);

    // EOB block after a full one: stale words must read zero
    applyStimulus(16'd100, 1'b0);
    applyStimulus(16'd7, 1'b0);
    applyStimulus(-16'sd5, 1'b1);
    compare("t4_x0", blk_x_zz[0*DW +: DW], 16'd100);
    compare("t4_x1", blk_x_zz[1*DW +: DW], 16'd7);
    compare("t4_x8", blk_x_zz[8*DW +: DW], 16'hFFFB);
    compare("t4_x2_zero", blk_x_zz[2*DW +: DW], 16'd0);
    idle(2);

    // 64 beats without s_last
    for (int k = 0; k < 64; k++) applyStimulus(DW'($urandom()), 1'b0);
    compare("t5_err", err_zz, 1'b1);
    compare("t5_launch", launch_zz, 1'b1);
    idle(LAT + 2);

    // Block A with random idle gaps
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      applyStimulus(DW'($urandom()), k == 63);
    end
    // B and C: 1-beat EOB blocks back to back, the C beat lands in B's launch cycle
    applyStimulus(DW'($urandom()), 1'b1);
    compare("t6_launch_b", launch_zz, 1'b1);
    applyStimulus(DW'($urandom()), 1'b1);
    compare("t6_launch_c", launch_zz, 1'b1);
    // D: 30 beats then a reset pulse
    for (int k = 0; k < 30; k++) applyStimulus(DW'($urandom()), 1'b0);
    valid = 1'b0;
    doReset(1);
    compare("t6_cnt_cleared", cnt_zz, 8'd0);
    idle(2);

    // Reset while an out_valid is still in flight
    for (int k = 0; k < 5; k++) applyStimulus(DW'($urandom()), k == 4);
    idle(10);
    doReset(1);
    idle(LAT + 5);

    // Next block starts filling at x0
    applyStimulus(16'h1234, 1'b0);
    applyStimulus(16'h0042, 1'b1);
    compare("t6_restart_x0", blk_x_zz[0*DW +: DW], 16'h1234);
    compare("t6_restart_x1_raster", blk_x_rs[1*DW +: DW], 16'h0042);
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
